// File: rtl/regfile_pkg.sv
// Shared constants and the operand-forwarding helper for the register file
// writeback path.
package regfile_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    // Register 0 reads as zero. Otherwise the in-flight writeback beats the stale array value.
    function automatic logic [DATA_W-1:0] fwd_pick(
        input logic [ADDR_W-1:0] rd_addr,
        input logic              wb_valid,
        input logic [ADDR_W-1:0] wb_addr,
        input logic [DATA_W-1:0] wb_data,
        input logic [DATA_W-1:0] rf_data
    );
        if (rd_addr == REG_ZERO)
            return '0;
        else if (wb_valid && (wb_addr == rd_addr))
            return wb_data;
        else
            return rf_data;
    endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination bits for long-latency ops, with two busy lookups for decode.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_rd,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_rd,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic              busy_1,
    output logic              busy_2
);
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    // Set is applied after clear so a re-issue in the accepting cycle stays pending.
    always_comb begin
        pending_nxt = pending;
        if (clr_en)
            pending_nxt[clr_rd] = 1'b0;
        if (set_en && (set_rd != REG_ZERO))
            pending_nxt[set_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    assign busy_1 = pending[rd_addr_1] && (rd_addr_1 != REG_ZERO);
    assign busy_2 = pending[rd_addr_2] && (rd_addr_2 != REG_ZERO);
endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Register file write-port arbiter and decode-side forwarding/hazard view.
// The ALU and the long-latency unit share one writeback register.
module regfile_writeback_ctrl
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_rd,
    input  logic [DATA_W-1:0] lu_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              rf_regwrite,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    input  logic [DATA_W-1:0] rf_data_1,
    input  logic [DATA_W-1:0] rf_data_2,
    output logic [DATA_W-1:0] fwd_data_1,
    output logic [DATA_W-1:0] fwd_data_2,
    output logic              busy_1,
    output logic              busy_2
);
    logic              lu_accept;
    logic              acc_valid;
    logic [ADDR_W-1:0] acc_rd;
    logic [DATA_W-1:0] acc_data;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    // Handshake: the long-latency result transfers in a cycle where lu_valid and
    // lu_ready are both high; the ALU cannot stall, so it simply takes the slot
    // and the long-latency unit must hold its payload until it gets through.
    assign lu_ready  = !reset && !alu_valid;
    assign lu_accept = lu_valid && lu_ready;

    always_comb begin
        acc_valid = 1'b0;
        acc_rd    = alu_rd;
        acc_data  = alu_data;
        if (alu_valid) begin
            acc_valid = 1'b1;
        end else if (lu_accept) begin
            acc_valid = 1'b1;
            acc_rd    = lu_rd;
            acc_data  = lu_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= acc_valid;
            if (acc_valid) begin
                wb_addr <= acc_rd;
                wb_data <= acc_data;
            end
        end
    end

    // Register 0 writes are dropped here so the array never holds a nonzero r0.
    assign rf_regwrite   = wb_valid && (wb_addr != REG_ZERO);
    assign rf_write_addr = wb_addr;
    assign rf_write_data = wb_data;

    assign fwd_data_1 = fwd_pick(rd_addr_1, wb_valid, wb_addr, wb_data, rf_data_1);
    assign fwd_data_2 = fwd_pick(rd_addr_2, wb_valid, wb_addr, wb_data, rf_data_2);

    regfile_scoreboard u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en    (issue_valid),
        .set_rd    (issue_rd),
        .clr_en    (lu_accept),
        .clr_rd    (lu_rd),
        .rd_addr_1 (rd_addr_1),
        .rd_addr_2 (rd_addr_2),
        .busy_1    (busy_1),
        .busy_2    (busy_2)
    );
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Directed bench for regfile_writeback_ctrl: a bench-side register array,
// a write scoreboard queue and immediate-assertion checks.
module tb_regfile_writeback_ctrl;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          lu_valid = 1'b0;
    logic          lu_ready;
    logic [AW-1:0] lu_rd = '0;
    logic [DW-1:0] lu_data = '0;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_rd = '0;
    logic          rf_regwrite;
    logic [AW-1:0] rf_write_addr;
    logic [DW-1:0] rf_write_data;
    logic [AW-1:0] rd_addr_1 = '0;
    logic [AW-1:0] rd_addr_2 = '0;
    logic [DW-1:0] rf_data_1;
    logic [DW-1:0] rf_data_2;
    logic [DW-1:0] fwd_data_1;
    logic [DW-1:0] fwd_data_2;
    logic          busy_1;
    logic          busy_2;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    rf_mem [32] = '{default: '0};
    logic [31:0]      tb_pend = '0;
    logic             p_stall = 1'b0;
    logic [AW-1:0]    p_rd = '0;
    logic [DW-1:0]    p_data = '0;

    regfile_writeback_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .lu_valid      (lu_valid),
        .lu_ready      (lu_ready),
        .lu_rd         (lu_rd),
        .lu_data       (lu_data),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .rf_regwrite   (rf_regwrite),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .rd_addr_1     (rd_addr_1),
        .rd_addr_2     (rd_addr_2),
        .rf_data_1     (rf_data_1),
        .rf_data_2     (rf_data_2),
        .fwd_data_1    (fwd_data_1),
        .fwd_data_2    (fwd_data_2),
        .busy_1        (busy_1),
        .busy_2        (busy_2)
    );

    // Clock and the register array that sits behind the write port.
    always #5 clk = ~clk;

    always @(posedge clk)
        if (rf_regwrite)
            rf_mem[rf_write_addr] <= rf_write_data;

    assign rf_data_1 = rf_mem[rd_addr_1];
    assign rf_data_2 = rf_mem[rd_addr_2];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every committed write must match the oldest expected one.
    always @(negedge clk) begin
        if (!reset && rf_regwrite) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL unexpected_write: observed addr %0d data %h expected none",
                       rf_write_addr, rf_write_data);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                check("wb_write", {27'd0, rf_write_addr}, {27'd0, e[AW+DW-1:DW]});
                check("wb_data", rf_write_data, e[DW-1:0]);
            end
        end
    end

    // Stimulus protocol rules, tracked from the bench's own view of acceptance.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tb_pend <= '0;
            p_stall <= 1'b0;
        end else begin
            assert (!(alu_valid && tb_pend[alu_rd])) else begin
                n_errors++;
                $error("FAIL proto_waw: observed alu_rd %0d pending expected not pending", alu_rd);
            end
            assert (!(lu_valid && !tb_pend[lu_rd])) else begin
                n_errors++;
                $error("FAIL proto_lu_pend: observed lu_rd %0d idle expected pending", lu_rd);
            end
            assert (!(p_stall && (!lu_valid || lu_rd != p_rd || lu_data != p_data))) else begin
                n_errors++;
                $error("FAIL proto_hold: observed lu payload changed expected held");
            end
            p_stall <= lu_valid && alu_valid;
            p_rd    <= lu_rd;
            p_data  <= lu_data;
            begin
                logic [31:0] nxt;
                nxt = tb_pend;
                if (lu_valid && !alu_valid) nxt[lu_rd] = 1'b0;
                if (issue_valid && issue_rd != 0) nxt[issue_rd] = 1'b1;
                tb_pend <= nxt;
            end
        end
    end

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        lu_valid    = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic drive_alu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
        if (rd != 0) exp_q.push_back({rd, d});
    endtask

    task automatic drive_lu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        lu_valid = 1'b1;
        lu_rd    = rd;
        lu_data  = d;
    endtask

    task automatic drive_issue(input logic [AW-1:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
    endtask

    initial begin
        // Reset state.
        #1;
        check("rst_regwrite", {31'd0, rf_regwrite}, 32'd0);
        check("rst_lu_ready", {31'd0, lu_ready}, 32'd0);
        check("rst_busy_2", {31'd0, busy_2}, 32'd0);
        step();
        step();
        reset = 1'b0;

        // ALU write, forwarded before it commits.
        drive_alu(5, 32'hDEADBEEF);
        rd_addr_1 = 5;
        step();
        idle();
        @(negedge clk);
        check("alu_regwrite_n1", {31'd0, rf_regwrite}, 32'd1);
        check("alu_addr_n1", {27'd0, rf_write_addr}, 32'd5);
        check("alu_fwd_n1", fwd_data_1, 32'hDEADBEEF);
        step();
        @(negedge clk);
        check("alu_regwrite_n2", {31'd0, rf_regwrite}, 32'd0);
        check("alu_fwd_n2", fwd_data_1, 32'hDEADBEEF);

        // Back-to-back ALU writes to r3.
        step();
        drive_alu(3, 32'd1);
        step();
        drive_alu(3, 32'd2);
        rd_addr_1 = 3;
        @(negedge clk);
        check("b2b_fwd_first", fwd_data_1, 32'd1);
        step();
        idle();
        @(negedge clk);
        check("b2b_fwd_second", fwd_data_1, 32'd2);
        step();
        @(negedge clk);
        check("b2b_rf_final", fwd_data_1, 32'd2);

        // Register 0.
        step();
        drive_alu(0, 32'hFFFFFFFF);
        drive_issue(0);
        rd_addr_1 = 0;
        rd_addr_2 = 0;
        step();
        idle();
        @(negedge clk);
        check("r0_regwrite", {31'd0, rf_regwrite}, 32'd0);
        check("r0_fwd", fwd_data_1, 32'd0);
        check("r0_busy", {31'd0, busy_2}, 32'd0);

        // Scoreboard on r12.
        step();
        drive_issue(12);
        rd_addr_2 = 12;
        step();
        idle();
        @(negedge clk);
        check("sb_busy_issued", {31'd0, busy_2}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            check("sb_busy_wait", {31'd0, busy_2}, 32'd1);
        end
        step();
        drive_lu(12, 32'hCAFE0012);
        exp_q.push_back({5'd12, 32'hCAFE0012});
        @(negedge clk);
        check("sb_lu_ready", {31'd0, lu_ready}, 32'd1);
        check("sb_busy_accept", {31'd0, busy_2}, 32'd1);
        step();
        idle();
        @(negedge clk);
        check("sb_busy_cleared", {31'd0, busy_2}, 32'd0);
        check("sb_fwd_lu", fwd_data_2, 32'hCAFE0012);
        step();
        drive_issue(12);
        step();
        idle();
        drive_lu(12, 32'h00005555);
        drive_issue(12);
        exp_q.push_back({5'd12, 32'h00005555});
        step();
        idle();
        @(negedge clk);
        check("sb_reissue_busy", {31'd0, busy_2}, 32'd1);
        check("sb_reissue_fwd", fwd_data_2, 32'h00005555);
        drive_lu(12, 32'h00006666);
        exp_q.push_back({5'd12, 32'h00006666});
        step();
        idle();
        @(negedge clk);
        check("sb_final_clear", {31'd0, busy_2}, 32'd0);

        // Collision: ALU holds the port for three cycles, lu payload held.
        step();
        drive_issue(9);
        step();
        idle();
        drive_lu(9, 32'h00001234);
        for (int i = 0; i < 3; i++) begin
            drive_alu(AW'(20 + i), 32'hA0 + i);
            @(negedge clk);
            check("col_lu_ready_low", {31'd0, lu_ready}, 32'd0);
            step();
        end
        alu_valid = 1'b0;
        exp_q.push_back({5'd9, 32'h00001234});
        @(negedge clk);
        check("col_lu_ready_high", {31'd0, lu_ready}, 32'd1);
        step();
        idle();
        @(negedge clk);
        check("col_lu_lands", {27'd0, rf_write_addr}, 32'd9);
        check("col_lu_regwrite", {31'd0, rf_regwrite}, 32'd1);

        // Reset mid-run with a writeback in flight and r7 pending.
        step();
        drive_alu(8, 32'h00000088);
        drive_issue(7);
        rd_addr_1 = 8;
        rd_addr_2 = 7;
        step();
        idle();
        reset = 1'b1;
        void'(exp_q.pop_back());
        #1;
        check("mid_rst_regwrite", {31'd0, rf_regwrite}, 32'd0);
        check("mid_rst_addr", {27'd0, rf_write_addr}, 32'd0);
        check("mid_rst_data", rf_write_data, 32'd0);
        check("mid_rst_lu_ready", {31'd0, lu_ready}, 32'd0);
        check("mid_rst_busy_2", {31'd0, busy_2}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("post_rst_rf8", fwd_data_1, 32'd0);
        for (int a = 1; a < 32; a++) begin
            rd_addr_1 = AW'(a);
            #1;
            check("post_rst_busy", {31'd0, busy_1}, 32'd0);
        end
        rd_addr_1 = 5;
        #1;
        check("post_rst_rf5", fwd_data_1, 32'hDEADBEEF);

        step();
        step();
        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
